st_symbol_unpacker: RTL
=======================

# st_symbol_unpacker

Avalon-ST data-format adapter that consumes the 32-bit packetised stream (4 symbols per beat, with `startofpacket`/`endofpacket`/`empty`) produced by the timing-adapter stage and emits it one 8-bit symbol per beat. It sits on the receive side of the FFT data path, feeding byte-wide consumers (checksum, UART/debug tap, byte FIFO). Both sides use ready latency 0. Sustained throughput is one output symbol per clock, with no bubble between input beats.

## Interface
Parameters:
- `SYMBOLS_PER_BEAT`, 4, symbols per input beat (power of two, ≥2)
- `SYMBOL_WIDTH`, 8, bits per symbol
- `EMPTY_WIDTH`, 2, log2(`SYMBOLS_PER_BEAT`)

Ports:
- `clk`  in  1  single clock. All logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid
- `in_data`  in  32  4 symbols; first symbol in bits [31:24]
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `in_startofpacket`  in  1  first beat of packet
- `in_endofpacket`  in  1  last beat of packet
- `in_empty`  in  2  unused trailing symbols; meaningful only on EOP beat
- `out_valid`  out  1  output symbol valid
- `out_data`  out  8  symbol
- `out_ready`  in  1  output symbol accepted when `out_valid && out_ready`
- `out_startofpacket`  out  1  first symbol of packet
- `out_endofpacket`  out  1  last valid symbol of packet

## Operation
- State:
  - holding register `hold_data[31:0]`, `hold_sop`, `hold_eop`, `last_idx[1:0]`
  - `full` flag
  - symbol index `idx[1:0]`
- On input accept:
  - load the holding register and set `full=1`, `idx=0`
  - `last_idx = in_endofpacket ? 3 - in_empty : 3`
  - `in_empty` is ignored when `in_endofpacket=0`.
- Outputs, combinational from registers:
  - `out_valid = full`
  - `out_data = hold_data[31-8*idx -: 8]`
  - `out_startofpacket = hold_sop && idx==0`
  - `out_endofpacket = hold_eop && idx==last_idx`
- Output handshake:
  - `drain = full && out_ready && idx==last_idx`
  - If `out_valid && out_ready && !drain`, then `idx <= idx+1`.
  - If `drain` and no input accept in the same cycle, then `full <= 0`.
- Input ready:
  - `in_ready = !reset && (!full || drain)`
  - This is combinational on `out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- Simultaneous drain and input accept: the new beat loads, `full` stays 1, and `idx=0`. There is no idle cycle.
- EOP beat with `in_empty=3`: exactly one symbol is emitted, and that symbol carries both SOP (if `hold_sop`) and EOP.
- No protocol checking. SOP/EOP are passed through as received, including EOP without a preceding SOP.

## Timing
- Reset, on the cycle `reset` is sampled high:
  - `full=0`, `idx=0`, `hold_*=0`
  - `out_valid=0`, `out_startofpacket=0`, `out_endofpacket=0`, `out_data=0`
  - `in_ready=0` while `reset` is high and 1 on the first cycle after release.
- Latency: a beat accepted at edge N presents its first symbol on `out_valid` from edge N (visible in cycle N+1).
- Throughput: a full beat takes 4 cycles of `out_ready=1`; the next beat can be accepted on the 4th cycle.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_startofpacket` and `out_endofpacket` hold stable.
- Reset mid-packet: the partial beat is discarded immediately. No EOP is generated.

## Test plan
- Single beat, `in_data=0x11223344`, SOP=EOP=1, `empty=0`, `out_ready=1`:
  - outputs 0x11 (SOP), 0x22, 0x33, 0x44 (EOP) on 4 consecutive cycles
  - `in_ready` is low for cycles 1-3 after the accept and high on cycle 4.
- 3-beat packet (0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3 with EOP, `empty=2`), `in_valid` held high:
  - 10 symbols with no gaps
  - SOP only on 0xA0, EOP on 0xC1
  - 0xC2 and 0xC3 are never emitted.
- EOP beat with `empty=3` and SOP=1, `in_data=0x5A000000`: one symbol 0x5A with SOP and EOP both set, and `in_ready` high the next cycle.
- Random `out_ready` (≈50%) over 1000 random packets: the output symbol sequence matches the reference model, and `out_data`/`out_*packet` are stable on every stalled cycle.
- `empty=2` on a non-EOP beat: all 4 symbols are emitted.
- Reset asserted after the 2nd symbol of 0xDEADBEEF is emitted: `out_valid=0` next cycle, and after release the next beat 0x01020304 emits 0x01 first.

Source files
------------

// File: rtl/st_symbol_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : st_symbol_unpacker
// Brief    : Avalon-ST adapter that splits multi-symbol beats into one-symbol
//            beats, preserving SOP/EOP and honouring the EOP empty count.
// Revision : 1.0 - initial release
// ============================================================================
module st_symbol_unpacker #(
   parameter int SYMBOLS_PER_BEAT = 4,
   parameter int SYMBOL_WIDTH     = 8,
   parameter int EMPTY_WIDTH      = 2
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     in_valid,
   input  logic [SYMBOLS_PER_BEAT*SYMBOL_WIDTH-1:0] in_data,
   output logic                                     in_ready,
   input  logic                                     in_startofpacket,
   input  logic                                     in_endofpacket,
   input  logic [EMPTY_WIDTH-1:0]                   in_empty,
   output logic                                     out_valid,
   output logic [SYMBOL_WIDTH-1:0]                  out_data,
   input  logic                                     out_ready,
   output logic                                     out_startofpacket,
   output logic                                     out_endofpacket
);

   localparam int                     c_DATA_W   = SYMBOLS_PER_BEAT * SYMBOL_WIDTH;
   localparam logic [EMPTY_WIDTH-1:0] c_LAST_IDX = EMPTY_WIDTH'(SYMBOLS_PER_BEAT - 1);

   logic [c_DATA_W-1:0]    r_hold_data;
   logic                   r_hold_sop;
   logic                   r_hold_eop;
   logic [EMPTY_WIDTH-1:0] r_last_idx;
   logic                   r_full;
   logic [EMPTY_WIDTH-1:0] r_idx;

   logic w_at_last;
   logic w_drain;
   logic w_accept;

   assign w_at_last = (r_idx == r_last_idx);
   assign w_drain   = r_full && out_ready && w_at_last;
   // Ready depends on out_ready only, so a new beat can load on the drain cycle.
   assign in_ready  = !reset && (!r_full || w_drain);
   assign w_accept  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold_data <= '0;
         r_hold_sop  <= 1'b0;
         r_hold_eop  <= 1'b0;
         r_last_idx  <= '0;
         r_full      <= 1'b0;
         r_idx       <= '0;
      end else if (w_accept) begin
         r_hold_data <= in_data;
         r_hold_sop  <= in_startofpacket;
         r_hold_eop  <= in_endofpacket;
         r_last_idx  <= in_endofpacket ? (c_LAST_IDX - in_empty) : c_LAST_IDX;
         r_full      <= 1'b1;
         r_idx       <= '0;
      end else if (w_drain) begin
         r_full <= 1'b0;
         r_idx  <= '0;
      end else if (r_full && out_ready) begin
         r_idx <= r_idx + EMPTY_WIDTH'(1);
      end
   end

   // First symbol of the beat lives in the most significant lane.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < SYMBOLS_PER_BEAT; i++) begin
         if (r_idx == EMPTY_WIDTH'(i)) begin
            out_data = r_hold_data[c_DATA_W-1-i*SYMBOL_WIDTH -: SYMBOL_WIDTH];
         end
      end
   end

   assign out_valid         = r_full;
   assign out_startofpacket = r_hold_sop && (r_idx == '0);
   assign out_endofpacket   = r_hold_eop && w_at_last;

endmodule
`default_nettype wire
